// File: rtl/forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit
//
// Forwarding and hazard-detection unit for a classic 5-stage in-order pipeline.
// The block keeps its own shadow copy of the pipeline control that matters for
// hazards (EX, MEM and WB slots). It produces the ALU operand-mux selects
// (ForwardA/ForwardB), the load-use stall and the branch flush. It also counts
// stall and flush cycles since reset.
//
// Ports
//   clk           in   pipeline clock, all state updates on the rising edge
//   rst           in   synchronous active-high reset
//   ID_rs1        in   [4:0] rs1 field of the instruction in ID
//   ID_rs2        in   [4:0] rs2 field of the instruction in ID
//   ID_rd         in   [4:0] rd field of the instruction in ID
//   ID_RegWrite   in   instruction in ID writes rd
//   ID_MemRead    in   instruction in ID is a load
//   Branch_taken  in   branch/jump resolved taken in EX this cycle
//   ForwardA      out  [1:0] operand A select: 00 regfile, 01 MEM_WB, 10 EX_MEM
//   ForwardB      out  [1:0] operand B select, same encoding
//   Stall         out  hold PC and IF/ID this cycle
//   Flush         out  squash IF/ID and ID/EX at the next edge
//   Stall_count   out  [CNT_W-1:0] load-use stall cycles since reset (wraps)
//   Flush_count   out  [CNT_W-1:0] flush cycles since reset (wraps)
//
// There is no FSM and no valid/ready handshake here. Every output is either
// combinational from the slot registers (forward selects) or from slot
// registers plus the ID fields (stall/flush), or a plain registered counter.
// -----------------------------------------------------------------------------
module forward_hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             Branch_taken,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Stall,
  output logic             Flush,
  output logic [CNT_W-1:0] Stall_count,
  output logic [CNT_W-1:0] Flush_count
);

  // Operand-mux select encodings. 2'b11 is never produced.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Shadow pipeline slots
  // ---------------------------------------------------------------------------
  logic [4:0] ex_rs1_q,      ex_rs1_d;
  logic [4:0] ex_rs2_q,      ex_rs2_d;
  logic [4:0] ex_rd_q,       ex_rd_d;
  logic       ex_regwrite_q, ex_regwrite_d;
  logic       ex_memread_q,  ex_memread_d;

  logic [4:0] mem_rd_q,       mem_rd_d;
  logic       mem_regwrite_q, mem_regwrite_d;

  logic [4:0] wb_rd_q,        wb_rd_d;
  logic       wb_regwrite_q,  wb_regwrite_d;

  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic load_use;
  logic stall_int;
  logic flush_int;
  logic insert_bubble;

  // ---------------------------------------------------------------------------
  // Forward select for one source register. The EX_MEM producer is younger than
  // the MEM_WB producer, so it is checked first. x0 is hardwired zero and is
  // never forwarded, even if some instruction "writes" it.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] m_rd,
    input logic       m_wr,
    input logic [4:0] w_rd,
    input logic       w_wr
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (m_wr && (m_rd != 5'd0) && (m_rd == src)) begin
      sel = FWD_MEM;
    end else if (w_wr && (w_rd != 5'd0) && (w_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Forward selects depend only on registered slot state, never on ID_* inputs.
  always_comb begin
    ForwardA = fwd_sel(ex_rs1_q, mem_rd_q, mem_regwrite_q, wb_rd_q, wb_regwrite_q);
    ForwardB = fwd_sel(ex_rs2_q, mem_rd_q, mem_regwrite_q, wb_rd_q, wb_regwrite_q);
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // A load in EX cannot forward its data until it reaches WB, so a consumer in
  // ID must wait one cycle. A taken branch squashes the consumer anyway, so the
  // flush wins and no stall cycle is spent.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_use  = ex_memread_q && (ex_rd_q != 5'd0) &&
                ((ex_rd_q == ID_rs1) || (ex_rd_q == ID_rs2));
    flush_int = Branch_taken;
    stall_int = load_use && !Branch_taken;
  end

  assign Stall = stall_int;
  assign Flush = flush_int;

  // A bubble enters EX on either a stall (the consumer is held in ID) or a
  // flush (the instruction in ID is on the wrong path).
  assign insert_bubble = stall_int || flush_int;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // MEM and WB always advance, so the load that caused a stall moves to MEM and
  // then WB while the bubble sits behind it. This is what makes the stall last
  // exactly one cycle and leaves the consumer forwarding from MEM_WB.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (insert_bubble) begin
      ex_rs1_d      = 5'd0;
      ex_rs2_d      = 5'd0;
      ex_rd_d       = 5'd0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
    end else begin
      ex_rs1_d      = ID_rs1;
      ex_rs2_d      = ID_rs2;
      ex_rd_d       = ID_rd;
      ex_regwrite_d = ID_RegWrite;
      ex_memread_d  = ID_MemRead;
    end

    mem_rd_d       = ex_rd_q;
    mem_regwrite_d = ex_regwrite_q;

    wb_rd_d        = mem_rd_q;
    wb_regwrite_d  = mem_regwrite_q;

    // Counters wrap naturally from all-ones to zero.
    stall_count_d = stall_int ? (stall_count_q + CNT_ONE) : stall_count_q;
    flush_count_d = flush_int ? (flush_count_q + CNT_ONE) : flush_count_q;
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset overrides everything, including a pending stall or
  // flush, so the counters do not advance on a reset edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs1_q       <= 5'd0;
      ex_rs2_q       <= 5'd0;
      ex_rd_q        <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= 5'd0;
      mem_regwrite_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_regwrite_q  <= 1'b0;
      stall_count_q  <= '0;
      flush_count_q  <= '0;
    end else begin
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_rd_q        <= wb_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign Stall_count = stall_count_q;
  assign Flush_count = flush_count_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_forward_hazard_unit
//
// Directed bench for forward_hazard_unit. Each step drives one cycle of ID-stage
// inputs and pushes the outputs expected during that cycle onto a scoreboard
// queue. The expectations are worked out by hand from the pipeline slot
// contents. The queue entry is popped and compared on the falling edge of the
// same cycle.
// -----------------------------------------------------------------------------
module tb_forward_hazard_unit;

  localparam int CNT_W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_regwrite, id_memread, branch_taken;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall, flush;
  logic [CNT_W-1:0] stall_count, flush_count;

  forward_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_rs1       (id_rs1),
    .ID_rs2       (id_rs2),
    .ID_rd        (id_rd),
    .ID_RegWrite  (id_regwrite),
    .ID_MemRead   (id_memread),
    .Branch_taken (branch_taken),
    .ForwardA     (fwd_a),
    .ForwardB     (fwd_b),
    .Stall        (stall),
    .Flush        (flush),
    .Stall_count  (stall_count),
    .Flush_count  (flush_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]       a;
    logic [1:0]       b;
    logic             s;
    logic             f;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input string field,
                     input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] expv);
    n_cmp++;
    assert (act === expv)
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, act, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t  e;
    string tag;
    n_cmp++;
    assert (exp_q.size() > 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected>0");
    end
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      chk(tag, "ForwardA",    {30'd0, fwd_a}, {30'd0, e.a});
      chk(tag, "ForwardB",    {30'd0, fwd_b}, {30'd0, e.b});
      chk(tag, "Stall",       {31'd0, stall}, {31'd0, e.s});
      chk(tag, "Flush",       {31'd0, flush}, {31'd0, e.f});
      chk(tag, "Stall_count", stall_count,    e.sc);
      chk(tag, "Flush_count", flush_count,    e.fc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one pipeline cycle. Inputs are applied just after the rising edge,
  // checked on the falling edge, then the next rising edge commits the state.
  // ---------------------------------------------------------------------------
  task automatic step(input string tag,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd,  input logic rw, input logic mr,
                      input logic bt, input logic r,
                      input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input logic ef,
                      input int esc, input int efc);
    exp_t e;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_regwrite  = rw;
    id_memread   = mr;
    branch_taken = bt;
    rst          = r;
    e.a  = ea;
    e.b  = eb;
    e.s  = es;
    e.f  = ef;
    e.sc = CNT_W'(esc);
    e.fc = CNT_W'(efc);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //    tag           rs1  rs2  rd  rw mr bt rst  A      B      S  F  sc fc
    // Reset state
    step("reset",       0,   0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);

    // EX_MEM then MEM_WB forwarding of x5
    step("add_x5",      1,   2,   5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step("use_rs1_x5",  5,   3,   6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step("fwd_mem_a",   8,   5,   9, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);
    step("fwd_wb_b",    0,   0,   0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);

    // Two back-to-back writers of x5: the younger one wins
    step("wr_x5_a",     0,   0,   5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step("wr_x5_b",     0,   0,   5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step("rd_x5",       5,   0,  10, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step("prio_mem",    0,   0,   0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);

    // Load-use stall on rs2
    step("load_x7",     1,   0,   7, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step("lu_stall",    2,   7,  11, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    step("lu_bubble",   2,   7,  11, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    step("lu_fwd_wb",   0,   0,   0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 1, 0);

    // Load-use coincident with a taken branch: the flush wins
    step("load_x7_br",  0,   0,   7, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    step("br_over_lu",  7,   0,  12, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, 1, 0);
    step("after_flush", 0,   0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);

    // x0 is never forwarded and a load to x0 never stalls
    step("wr_x0_a",     0,   0,   0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
    step("wr_x0_b",     0,   0,   0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
    step("rd_x0_mem",   0,   0,  13, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
    step("ld_x0",       0,   0,   0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
    step("ld_x0_use",   0,   0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);

    // Reset during a stall cycle with nonzero counters
    step("load_x7_rst", 0,   0,   7, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
    step("rst_in_stall",7,   0,  14, 1, 0, 0, 1, 2'b00, 2'b00, 1, 0, 1, 1);
    step("post_rst",    7,   7,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step("post_rst_wb", 0,   0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);

    // A flush drives Flush combinationally and counts once
    step("flush_only",  0,   0,   0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0);
    step("flush_cnt",   0,   0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);

    n_cmp++;
    assert (exp_q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard bound so the run always ends even if the driver stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
